// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary64 field constants, default quiet NaN,
// multiplier FSM states and an operand classification helper.
package fpu_pkg;

  localparam int unsigned EXP_BIAS = 1023;
  localparam logic [10:0] EXP_MAX  = 11'h7FF;
  localparam int unsigned MANT_W   = 52;
  localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    MUL,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
  } fp_class_t;

  function automatic fp_class_t classify(input logic [63:0] x);
    fp_class_t c;
    c.is_nan  = (x[62:52] == EXP_MAX) && (x[51:0] != '0);
    c.is_inf  = (x[62:52] == EXP_MAX) && (x[51:0] == '0);
    c.is_zero = (x[62:52] == '0) && (x[51:0] == '0);
    c.is_sub  = (x[62:52] == '0) && (x[51:0] != '0);
    return c;
  endfunction

endpackage

// File: rtl/fp64_round_pack.sv
// Round-to-nearest-even and pack of a normalised binary64 significand;
// saturates to Inf on overflow and flushes to zero on underflow.
module fp64_round_pack
  import fpu_pkg::*;
(
  input  logic                     i_sign,
  input  logic signed [12:0]       i_exp,
  input  logic        [MANT_W-1:0] i_mant,
  input  logic                     i_guard,
  input  logic                     i_sticky,
  output logic        [63:0]       o_y,
  output logic                     o_inexact,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  logic              w_inc;
  logic [MANT_W:0]   w_sum;
  logic signed [12:0] w_exp;

  always_comb begin
    w_inc       = i_guard & (i_sticky | i_mant[0]);
    w_sum       = {1'b0, i_mant} + {{MANT_W{1'b0}}, w_inc};
    // A rounding carry leaves the fraction field at zero and bumps the exponent.
    w_exp       = i_exp + $signed({12'd0, w_sum[MANT_W]});
    o_y         = '0;
    o_inexact   = 1'b0;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_exp >= 13'sd2047) begin
      o_y        = {i_sign, EXP_MAX, {MANT_W{1'b0}}};
      o_overflow = 1'b1;
      o_inexact  = 1'b1;
    end else if (w_exp <= 13'sd0) begin
      o_y         = {i_sign, 63'd0};
      o_underflow = 1'b1;
      o_inexact   = 1'b1;
    end else begin
      o_y       = {i_sign, w_exp[10:0], w_sum[MANT_W-1:0]};
      o_inexact = i_guard | i_sticky;
    end
  end

endmodule

// File: rtl/fp64_mul_seq.sv
// Multi-cycle binary64 multiplier, shift-add mantissa datapath, valid/ready.
// Define FP64_MUL_RADIX4_EN to retire two multiplier bits per MUL cycle.
module fp64_mul_seq
  import fpu_pkg::*;
#(
  parameter logic [63:0] QNAN = fpu_pkg::QNAN
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y,
  output logic        invalid,
  output logic        inexact,
  output logic        overflow,
  output logic        underflow
);

`ifdef FP64_MUL_RADIX4_EN
  localparam logic [5:0] MUL_LAST = 6'd26;
`else
  localparam logic [5:0] MUL_LAST = 6'd52;
`endif

  state_t r_state, w_next;

  logic               r_sign;
  logic        [52:0] r_ma, r_mb;
  logic signed [12:0] r_ea, r_eb;
  logic       [105:0] r_acc, r_mcand;
`ifdef FP64_MUL_RADIX4_EN
  logic       [105:0] r_m3;
`endif
  logic        [52:0] r_mplier;
  logic         [5:0] r_cnt;
  logic        [63:0] r_y;
  logic               r_invalid, r_inexact, r_overflow, r_underflow;

  fp_class_t          w_ca, w_cb;
  logic               w_special, w_sub_any, w_load_mul, w_norm_done;
  logic        [63:0] w_spec_y;
  logic               w_spec_inv;
  logic        [52:0] w_a_mant, w_b_mant, w_ma_sh, w_mb_sh, w_ld_ma, w_ld_mb;
  logic signed [12:0] w_a_exp, w_b_exp, w_ea_sh, w_eb_sh, w_e, w_e_rnd;
  logic        [51:0] w_rp_mant;
  logic               w_rp_guard, w_rp_sticky;
  logic        [63:0] w_rp_y;
  logic               w_rp_inexact, w_rp_overflow, w_rp_underflow;

  always_comb begin
    w_ca       = classify(a);
    w_cb       = classify(b);
    w_special  = w_ca.is_nan | w_ca.is_inf | w_ca.is_zero |
                 w_cb.is_nan | w_cb.is_inf | w_cb.is_zero;
    w_sub_any  = w_ca.is_sub | w_cb.is_sub;
    w_a_mant   = {~w_ca.is_sub, a[51:0]};
    w_b_mant   = {~w_cb.is_sub, b[51:0]};
    w_a_exp    = w_ca.is_sub ? 13'sd1 : $signed({2'b00, a[62:52]});
    w_b_exp    = w_cb.is_sub ? 13'sd1 : $signed({2'b00, b[62:52]});
    w_spec_inv = 1'b0;
    if (w_ca.is_nan) begin
      w_spec_y = a | 64'h0008_0000_0000_0000;
    end else if (w_cb.is_nan) begin
      w_spec_y = b | 64'h0008_0000_0000_0000;
    end else if ((w_ca.is_zero & w_cb.is_inf) | (w_ca.is_inf & w_cb.is_zero)) begin
      w_spec_y   = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_ca.is_inf | w_cb.is_inf) begin
      w_spec_y = {a[63] ^ b[63], EXP_MAX, {MANT_W{1'b0}}};
    end else begin
      w_spec_y = {a[63] ^ b[63], 63'd0};
    end
  end

  always_comb begin
    w_ma_sh     = r_ma[52] ? r_ma : {r_ma[51:0], 1'b0};
    w_mb_sh     = r_mb[52] ? r_mb : {r_mb[51:0], 1'b0};
    w_ea_sh     = r_ma[52] ? r_ea : r_ea - 13'sd1;
    w_eb_sh     = r_mb[52] ? r_eb : r_eb - 13'sd1;
    w_norm_done = (w_ma_sh[52] & w_mb_sh[52]) | (r_cnt == 6'd51);
    w_load_mul  = (r_state == IDLE & in_valid & ~w_special & ~w_sub_any) |
                  (r_state == NORM & w_norm_done);
    w_ld_ma     = (r_state == IDLE) ? w_a_mant : w_ma_sh;
    w_ld_mb     = (r_state == IDLE) ? w_b_mant : w_mb_sh;
  end

  always_comb begin
    w_e         = r_ea + r_eb - $signed(13'(EXP_BIAS));
    w_e_rnd     = r_acc[105] ? w_e + 13'sd1 : w_e;
    w_rp_mant   = r_acc[105] ? r_acc[104:53] : r_acc[103:52];
    w_rp_guard  = r_acc[105] ? r_acc[52] : r_acc[51];
    w_rp_sticky = r_acc[105] ? |r_acc[51:0] : |r_acc[50:0];
  end

  fp64_round_pack u_round (
    .i_sign      (r_sign),
    .i_exp       (w_e_rnd),
    .i_mant      (w_rp_mant),
    .i_guard     (w_rp_guard),
    .i_sticky    (w_rp_sticky),
    .o_y         (w_rp_y),
    .o_inexact   (w_rp_inexact),
    .o_overflow  (w_rp_overflow),
    .o_underflow (w_rp_underflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (in_valid) w_next = w_special ? DONE : (w_sub_any ? NORM : MUL);
      NORM:  if (w_norm_done) w_next = MUL;
      MUL:   if (r_cnt == 6'd0) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
`ifdef FP64_MUL_RADIX4_EN
      r_m3        <= '0;
`endif
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_y         <= '0;
      r_invalid   <= 1'b0;
      r_inexact   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign <= a[63] ^ b[63];
          r_ma   <= w_a_mant;
          r_mb   <= w_b_mant;
          r_ea   <= w_a_exp;
          r_eb   <= w_b_exp;
          r_cnt  <= '0;
          if (w_special) begin
            r_y         <= w_spec_y;
            r_invalid   <= w_spec_inv;
            r_inexact   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end
        end
        NORM: begin
          r_ma  <= w_ma_sh;
          r_mb  <= w_mb_sh;
          r_ea  <= w_ea_sh;
          r_eb  <= w_eb_sh;
          r_cnt <= r_cnt + 6'd1;
        end
        MUL: begin
`ifdef FP64_MUL_RADIX4_EN
          case (r_mplier[1:0])
            2'b01:   r_acc <= r_acc + r_mcand;
            2'b10:   r_acc <= r_acc + {r_mcand[104:0], 1'b0};
            2'b11:   r_acc <= r_acc + r_m3;
            default: ;
          endcase
          r_m3     <= {r_m3[103:0], 2'b00};
          r_mcand  <= {r_mcand[103:0], 2'b00};
          r_mplier <= {2'b00, r_mplier[52:2]};
`else
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= {r_mcand[104:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[52:1]};
`endif
          r_cnt <= r_cnt - 6'd1;
        end
        ROUND: begin
          r_y         <= w_rp_y;
          r_invalid   <= 1'b0;
          r_inexact   <= w_rp_inexact;
          r_overflow  <= w_rp_overflow;
          r_underflow <= w_rp_underflow;
        end
        default: ;
      endcase
      // Overrides the per-state counter update when MUL starts.
      if (w_load_mul) begin
        r_acc    <= '0;
        r_mcand  <= {53'd0, w_ld_ma};
        r_mplier <= w_ld_mb;
        r_cnt    <= MUL_LAST;
`ifdef FP64_MUL_RADIX4_EN
        r_m3     <= {53'd0, w_ld_ma} + {52'd0, w_ld_ma, 1'b0};
`endif
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign y         = r_y;
  assign invalid   = r_invalid;
  assign inexact   = r_inexact;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_fp64_mul_seq.sv
// Self-checking bench for fp64_mul_seq against a behavioural binary64 product model.
module tb_fp64_mul_seq;

`ifdef FP64_MUL_RADIX4_EN
  localparam int MULC = 27;
`else
  localparam int MULC = 53;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, y;
  logic        invalid, inexact, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  fp64_mul_seq #(.QNAN(64'h7FF8_0000_0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .invalid(invalid), .inexact(inexact), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Result packed as {y, invalid, inexact, overflow, underflow}.
  function automatic logic [67:0] ref_mul(input logic [63:0] x, input logic [63:0] z);
    logic s, nx, nz, ix, iz, zx, zz, g, st;
    logic [10:0] ex, ez;
    logic [52:0] mx, mz, r;
    logic [105:0] p, pn;
    logic [51:0] mant;
    int k, be;
    s  = x[63] ^ z[63];
    ex = x[62:52];
    ez = z[62:52];
    nx = (ex == 11'h7FF) && (x[51:0] != 0);
    nz = (ez == 11'h7FF) && (z[51:0] != 0);
    ix = (ex == 11'h7FF) && (x[51:0] == 0);
    iz = (ez == 11'h7FF) && (z[51:0] == 0);
    zx = (ex == 0) && (x[51:0] == 0);
    zz = (ez == 0) && (z[51:0] == 0);
    if (nx) return {x | 64'h0008_0000_0000_0000, 4'b0000};
    if (nz) return {z | 64'h0008_0000_0000_0000, 4'b0000};
    if ((zx && iz) || (ix && zz)) return {64'h7FF8_0000_0000_0000, 4'b1000};
    if (ix || iz) return {s, 11'h7FF, 52'd0, 4'b0000};
    if (zx || zz) return {s, 63'd0, 4'b0000};
    mx = {ex != 0, x[51:0]};
    mz = {ez != 0, z[51:0]};
    p  = {53'd0, mx} * {53'd0, mz};
    k  = 0;
    for (int i = 0; i < 106; i++) if (p[i]) k = i;
    pn   = p << (105 - k);
    be   = k + ((ex == 0) ? 1 : int'(ex)) + ((ez == 0) ? 1 : int'(ez)) - 1127;
    mant = pn[104:53];
    g    = pn[52];
    st   = |pn[51:0];
    r    = {1'b0, mant} + {52'd0, g & (st | mant[0])};
    if (r[52]) be = be + 1;
    if (be >= 2047) return {s, 11'h7FF, 52'd0, 4'b0110};
    if (be <= 0) return {s, 63'd0, 4'b0101};
    return {s, 11'(be), r[51:0], 1'b0, g | st, 2'b00};
  endfunction

  function automatic int norm_shifts(input logic [63:0] x);
    int m;
    if (x[62:52] != 0 || x[51:0] == 0) return 0;
    m = 0;
    for (int i = 0; i < 52; i++) if (x[i]) m = i;
    return 52 - m;
  endfunction

  function automatic int ref_lat(input logic [63:0] x, input logic [63:0] z);
    int na, nb;
    if (x[62:52] == 11'h7FF || z[62:52] == 11'h7FF ||
        x[62:0] == 0 || z[62:0] == 0) return 1;
    na = norm_shifts(x);
    nb = norm_shifts(z);
    return 2 + ((na > nb) ? na : nb) + MULC;
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] t;
    logic [51:0] f;
    logic [10:0] e;
    int unsigned c;
    t = {$urandom(), $urandom()};
    f = t[51:0];
    c = $urandom_range(0, 9);
    case (c)
      0: begin
        e = 11'd0;
        if ($urandom_range(0, 1) == 1) f = f >> $urandom_range(0, 51);
        if (f == 0) f = 52'd1;
      end
      1: begin
        case ($urandom_range(0, 2))
          0:       begin e = 11'd0;     f = 52'd0; end
          1:       begin e = 11'h7FF;   f = 52'd0; end
          default: begin e = 11'h7FF;   if (f == 0) f = 52'd5; end
        endcase
      end
      2:       e = 11'($urandom_range(1800, 2046));
      3:       e = 11'($urandom_range(1, 250));
      default: e = 11'($urandom_range(900, 1150));
    endcase
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  task automatic issue_op(input logic [63:0] ta, input logic [63:0] tb);
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [67:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = {y, invalid, inexact, overflow, underflow};
  endtask

  task automatic accept_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb,
                        output logic [67:0] res, output int lat);
    issue_op(ta, tb);
    wait_done(res, lat);
    accept_out();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, y, invalid, inexact, overflow, underflow} !== {2'b01, 68'd0})
      $display("FAIL reset_state: got ov=%b ir=%b y=%h flags=%b, expected ov=0 ir=1 y=0 flags=0",
               out_valid, in_ready, y, {invalid, inexact, overflow, underflow});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [67:0] vr [6];
    int          vl [6];
    logic [67:0] res;
    int          lat;
    va[0] = 64'h3FF8000000000000; vb[0] = 64'h4000000000000000;
    vr[0] = {64'h4008000000000000, 4'b0000}; vl[0] = 2 + MULC;
    va[1] = 64'h0000000000000000; vb[1] = 64'h7FF0000000000000;
    vr[1] = {64'h7FF8000000000000, 4'b1000}; vl[1] = 1;
    va[2] = 64'h3FF0000000000001; vb[2] = 64'h3FF0000000000001;
    vr[2] = {64'h3FF0000000000002, 4'b0100}; vl[2] = 2 + MULC;
    va[3] = 64'h7FE0000000000000; vb[3] = 64'hC000000000000000;
    vr[3] = {64'hFFF0000000000000, 4'b0110}; vl[3] = 2 + MULC;
    va[4] = 64'h0010000000000000; vb[4] = 64'h3FE0000000000000;
    vr[4] = {64'h0000000000000000, 4'b0101}; vl[4] = 2 + MULC;
    va[5] = 64'h0000000000000001; vb[5] = 64'h4330000000000000;
    vr[5] = {64'h0010000000000000, 4'b0000}; vl[5] = 2 + 52 + MULC;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], res, lat);
      n_checks++;
      if (res !== vr[i])
        $display("FAIL directed_%0d result: got y=%h flags=%b, expected y=%h flags=%b",
                 i, res[67:4], res[3:0], vr[i][67:4], vr[i][3:0]);
      else n_pass++;
      n_checks++;
      if (lat !== vl[i])
        $display("FAIL directed_%0d latency: got %0d, expected %0d", i, lat, vl[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [63:0] ta, tb;
    logic [67:0] res, exp_res;
    int          lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      ta = rand_fp();
      tb = rand_fp();
      exp_res = ref_mul(ta, tb);
      exp_lat = ref_lat(ta, tb);
      run_op(ta, tb, res, lat);
      n_checks++;
      if (res !== exp_res)
        $display("FAIL random_%0d result a=%h b=%h: got y=%h flags=%b, expected y=%h flags=%b",
                 i, ta, tb, res[67:4], res[3:0], exp_res[67:4], exp_res[3:0]);
      else n_pass++;
      n_checks++;
      if (lat !== exp_lat)
        $display("FAIL random_%0d latency a=%h b=%h: got %0d, expected %0d",
                 i, ta, tb, lat, exp_lat);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ta, tb;
    logic [67:0] res, exp_res;
    int          lat;
    ta = 64'h3FF5555555555555;
    tb = 64'hC00AAAAAAAAAAAAB;
    exp_res = ref_mul(ta, tb);
    issue_op(ta, tb);
    wait_done(res, lat);
    n_checks++;
    if (res !== exp_res)
      $display("FAIL backpressure_result: got %h, expected %h", res, exp_res);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = rand_fp();
      b = rand_fp();
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, y, invalid, inexact, overflow, underflow} !== {2'b10, exp_res})
        $display("FAIL backpressure_hold_%0d: got ov=%b ir=%b res=%h, expected ov=1 ir=0 res=%h",
                 i, out_valid, in_ready, {y, invalid, inexact, overflow, underflow}, exp_res);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL backpressure_release: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
    else n_pass++;
    ta = 64'h4024000000000000;
    tb = 64'h3FB999999999999A;
    run_op(ta, tb, res, lat);
    n_checks++;
    if (res !== ref_mul(ta, tb))
      $display("FAIL backpressure_next_op: got %h, expected %h", res, ref_mul(ta, tb));
    else n_pass++;
    n_checks++;
    if (lat !== 2 + MULC)
      $display("FAIL backpressure_next_lat: got %0d, expected %0d", lat, 2 + MULC);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] ta, tb;
    logic [67:0] res;
    int          lat;
    issue_op(64'h400921FB54442D18, 64'h4005BF0A8B145769);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, y, invalid, inexact, overflow, underflow} !== {2'b01, 68'd0})
      $display("FAIL reset_mid_state: got ov=%b ir=%b y=%h, expected ov=0 ir=1 y=0",
               out_valid, in_ready, y);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ta = 64'hBFF0000000000003;
    tb = 64'h3FF8000000000001;
    run_op(ta, tb, res, lat);
    n_checks++;
    if (res !== ref_mul(ta, tb))
      $display("FAIL reset_mid_next_op: got %h, expected %h", res, ref_mul(ta, tb));
    else n_pass++;
    n_checks++;
    if (lat !== 2 + MULC)
      $display("FAIL reset_mid_next_lat: got %0d, expected %0d", lat, 2 + MULC);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
